// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  localparam int MAX_DEV = 8;
  localparam int OWNER_W = $clog2(MAX_DEV);

  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/pci_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or above ptr, wrapping.
module rr_picker
  import pci_arb_pkg::*;
#(
  parameter int NUM_DEV = 4
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);

  // Walk offsets from farthest to nearest so the nearest active request is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int off = NUM_DEV - 1; off >= 0; off--) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if (req[i] && (i == ((int'(ptr) + off) % NUM_DEV))) begin
          winner = OWNER_W'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI central arbiter: round-robin grant, bus-idle tracking, unused-grant timeout.
// Optional grant parking on PARK_DEV when built with PCI_ARB_PARKING_EN.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_DEV  = 4,
  parameter int TIMEOUT  = 16,
  parameter int PARK_DEV = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DEV-1:0] request,
  input  logic               iframe,
  input  logic               iready,
  output logic [NUM_DEV-1:0] grant,
  output logic [2:0]         owner,
  output logic               bus_busy
);

  localparam int                 CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [NUM_DEV-1:0] GNT_NONE = '1;

  if (NUM_DEV < 2 || NUM_DEV > MAX_DEV || PARK_DEV < 0 || PARK_DEV >= NUM_DEV) begin : g_bad_cfg
    $error("pci_arbiter: NUM_DEV or PARK_DEV out of range");
  end

  function automatic logic [NUM_DEV-1:0] grant_for(input logic [OWNER_W-1:0] idx);
    logic [NUM_DEV-1:0] g;
    for (int i = 0; i < NUM_DEV; i++) g[i] = (idx != OWNER_W'(i));
    return g;
  endfunction

  function automatic logic [OWNER_W-1:0] ptr_after(input logic [OWNER_W-1:0] idx);
    return (idx == OWNER_W'(NUM_DEV - 1)) ? '0 : idx + OWNER_W'(1);
  endfunction

  arb_state_e          state_q, state_d;
  logic [OWNER_W-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_DEV-1:0]  grant_d;
  logic [OWNER_W-1:0]  owner_d;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_vld;
  logic                bus_idle;
  logic                owner_released;

  assign bus_idle = iframe & iready;

  rr_picker #(.NUM_DEV(NUM_DEV)) u_picker (
    .req    (~request),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    owner_released = 1'b1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (owner == OWNER_W'(i)) owner_released = request[i];
    end
  end

`ifdef PCI_ARB_PARKING_EN
  logic parked;
  assign parked = (grant != GNT_NONE);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    owner_d = owner;
    case (state_q)
      IDLE: begin
`ifdef PCI_ARB_PARKING_EN
        if (parked && !iframe) begin
          state_d = BUSY;
        end else if (pick_vld) begin
          // A competing request first drops the park grant so the bus turns around.
          if (parked && pick_idx != OWNER_W'(PARK_DEV)) begin
            grant_d = GNT_NONE;
          end else if (bus_idle) begin
            grant_d = grant_for(pick_idx);
            owner_d = pick_idx;
            cnt_d   = '0;
            state_d = GRANT;
          end else begin
            grant_d = GNT_NONE;
          end
        end else if (bus_idle) begin
          grant_d = grant_for(OWNER_W'(PARK_DEV));
          owner_d = OWNER_W'(PARK_DEV);
        end else begin
          grant_d = GNT_NONE;
        end
`else
        grant_d = GNT_NONE;
        if (pick_vld && bus_idle) begin
          grant_d = grant_for(pick_idx);
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
`endif
      end
      GRANT: begin
        if (!iframe) begin
          state_d = BUSY;
        end else if (owner_released) begin
          grant_d = GNT_NONE;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          grant_d = GNT_NONE;
          ptr_d   = ptr_after(owner);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BUSY: begin
        if (bus_idle) begin
          grant_d = GNT_NONE;
          ptr_d   = ptr_after(owner);
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant    <= GNT_NONE;
      owner    <= '0;
      bus_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant    <= grant_d;
      owner    <= owner_d;
      bus_busy <= (state_d == BUSY);
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter (NUM_DEV=4, TIMEOUT=16); parking checks when PCI_ARB_PARKING_EN is defined.
module tb_pci_arbiter;
  import pci_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic         iframe;
  logic         iready;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         bus_busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lat;
  int n;

  always #5 clk = ~clk;

  pci_arbiter #(.NUM_DEV(N), .TIMEOUT(TO), .PARK_DEV(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .request  (request),
    .iframe   (iframe),
    .iready   (iready),
    .grant    (grant),
    .owner    (owner),
    .bus_busy (bus_busy)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int gnt_of(input int d);
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = (i != d);
    return int'(g);
  endfunction

  task automatic apply_reset();
    reset   = 1'b1;
    request = '1;
    iframe  = 1'b1;
    iready  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) for a grant, then pop the expected owner and compare.
  task automatic wait_grant(input string tag, output int cycles);
    int exp;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (grant == '1 && cycles < 40);
    check_eq({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    exp = exp_q.pop_front();
    check_eq({tag, "_grant"}, int'(grant), gnt_of(exp));
    check_eq({tag, "_owner"}, int'(owner), exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    check_eq("rst_grant", int'(grant), 'hF);
    check_eq("rst_owner", int'(owner), 0);
    check_eq("rst_busy", int'(bus_busy), 0);
    check_eq("rst_state", int'(dut.state_q), int'(IDLE));

`ifdef PCI_ARB_PARKING_EN
    @(negedge clk);
    check_eq("park_grant", int'(grant), 'hE);
    check_eq("park_owner", int'(owner), 0);
    request = 4'b0111;
    @(negedge clk);
    check_eq("park_gap", int'(grant), 'hF);
    exp_q.push_back(3);
    wait_grant("park_win", lat);
    check_eq("park_win_lat", lat, 1);
    request = '1;
    @(negedge clk);
    check_eq("park_withdraw", int'(grant), 'hF);
    @(negedge clk);
    check_eq("repark", int'(grant), 'hE);
    iframe = 1'b0;
    @(negedge clk);
    check_eq("park_busy", int'(bus_busy), 1);
    check_eq("park_busy_grant", int'(grant), 'hE);
    iframe = 1'b1;
    @(negedge clk);
    check_eq("park_busy_exit", int'(grant), 'hF);
    check_eq("park_busy_clr", int'(bus_busy), 0);
    @(negedge clk);
    check_eq("repark2", int'(grant), 'hE);
`else
    // Single transaction from device 0.
    request = 4'b1110;
    exp_q.push_back(0);
    wait_grant("t1", lat);
    check_eq("t1_lat", lat, 1);
    check_eq("t1_state", int'(dut.state_q), int'(GRANT));
    iframe  = 1'b0;
    request = '1;
    @(negedge clk);
    check_eq("t1_busy", int'(bus_busy), 1);
    check_eq("t1_busy_grant", int'(grant), 'hE);
    iframe = 1'b1;
    iready = 1'b0;
    @(negedge clk);
    check_eq("t1_data_phase", int'(bus_busy), 1);
    iready = 1'b1;
    @(negedge clk);
    check_eq("t1_release", int'(grant), 'hF);
    check_eq("t1_busy_clr", int'(bus_busy), 0);

    // Everyone requesting: strict rotation with a turnaround cycle between owners.
    apply_reset();
    request = 4'b0000;
    for (int d = 0; d < N; d++) begin
      exp_q.push_back(d);
      wait_grant($sformatf("t2_d%0d", d), lat);
      iframe = 1'b0;
      @(negedge clk);
      check_eq($sformatf("t2_busy_d%0d", d), int'(bus_busy), 1);
      iframe = 1'b1;
      @(negedge clk);
      check_eq($sformatf("t2_turn_d%0d", d), int'(grant), 'hF);
    end
    request = '1;

    // Unused grant times out after TO cycles; pointer moves past device 1.
    request = 4'b1101;
    exp_q.push_back(1);
    wait_grant("t3", lat);
    n = 1;
    for (int k = 0; k < 40 && grant != '1; k++) begin
      @(negedge clk);
      if (grant != '1) n++;
    end
    check_eq("t3_timeout_len", n, TO);
    request = 4'b0101;
    exp_q.push_back(3);
    wait_grant("t3_next", lat);
    request = '1;
    @(negedge clk);
    check_eq("t3_withdraw", int'(grant), 'hF);

    // Withdrawal leaves the pointer alone: device 2 wins again over device 3.
    request = 4'b1011;
    exp_q.push_back(2);
    wait_grant("t4", lat);
    request = '1;
    @(negedge clk);
    check_eq("t4_withdraw", int'(grant), 'hF);
    request = 4'b0011;
    exp_q.push_back(2);
    wait_grant("t4_again", lat);
    request = '1;
    @(negedge clk);

    // iframe on the timeout edge wins.
    request = 4'b1110;
    exp_q.push_back(0);
    wait_grant("t5", lat);
    repeat (TO - 1) @(negedge clk);
    check_eq("t5_pre", int'(grant), 'hE);
    iframe = 1'b0;
    @(negedge clk);
    check_eq("t5_busy", int'(bus_busy), 1);
    check_eq("t5_grant", int'(grant), 'hE);
    iframe  = 1'b1;
    request = '1;
    @(negedge clk);
    check_eq("t5_release", int'(grant), 'hF);

    // Withdrawal on the timeout edge counts as withdrawal (pointer stays on 1).
    request = 4'b1101;
    exp_q.push_back(1);
    wait_grant("t6", lat);
    repeat (TO - 1) @(negedge clk);
    request = '1;
    @(negedge clk);
    check_eq("t6_withdraw", int'(grant), 'hF);
    request = 4'b1100;
    exp_q.push_back(1);
    wait_grant("t6_again", lat);
    request = '1;
    @(negedge clk);

    // Asynchronous reset in the middle of a transaction.
    apply_reset();
    request = 4'b1101;
    exp_q.push_back(1);
    wait_grant("t7", lat);
    iframe = 1'b0;
    @(negedge clk);
    check_eq("t7_busy", int'(bus_busy), 1);
    reset = 1'b1;
    #1;
    check_eq("t7_async_grant", int'(grant), 'hF);
    check_eq("t7_async_owner", int'(owner), 0);
    check_eq("t7_async_busy", int'(bus_busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t7_post_grant", int'(grant), 'hF);
    check_eq("t7_post_state", int'(dut.state_q), int'(IDLE));
    iframe  = 1'b1;
    request = '1;
    @(negedge clk);
    check_eq("t7_idle", int'(dut.state_q), int'(IDLE));
`endif

    check_eq("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
